// File: rtl/t01_audio_pkg.sv
// Shared types and constants for the sound-effect mixer and its sigma-delta output stage.
package t01_audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BLIP = 2'd1,
        GAP  = 2'd2
    } sfx_state_t;

    localparam int         MIX_W     = 8;
    localparam int         VOL_STEP  = 32;
    localparam int         SFX_GAIN  = 8;
    localparam logic [3:0] ENV_CLEAR = 4'd15;
    localparam logic [3:0] ENV_LAND  = 4'd8;

    // A line clear never plays more than four blips, however many lines are reported.
    function automatic logic [2:0] clamp_repeats(input logic [2:0] lines);
        return (lines > 3'd4) ? 3'd4 : lines;
    endfunction

endpackage

// File: rtl/t01_sigma_delta.sv
// First-order sigma-delta: 8-bit level in, 1-bit speaker drive out (duty = level/256).
module t01_sigma_delta
    import t01_audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [MIX_W-1:0] level_i,
    output logic             pwm_o
);

    logic [MIX_W-1:0] acc_q;
    logic             pwm_q;
    logic [MIX_W:0]   sum_d;

    assign sum_d = {1'b0, acc_q} + {1'b0, level_i};

    // Accumulate the level; the overflow carry becomes the next output bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            acc_q <= sum_d[MIX_W-1:0];
            pwm_q <= sum_d[MIX_W];
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/t01_sfx_mixer.sv
// Sound-effect sequencer (land tone, line-clear jingle) mixed with the music stream,
// scaled by volume, muted on request and sent to the speaker through a sigma-delta stage.
module t01_sfx_mixer
    import t01_audio_pkg::*;
#(
    parameter int SFX_TICK   = 250000,
    parameter int TONE_LAND  = 60000,
    parameter int TONE_CLEAR = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       square_in,
    input  logic       gameover,
    input  logic       mute,
    input  logic [1:0] vol,
    input  logic       sfx_land,
    input  logic [2:0] sfx_clear,
    output logic       pwm_out,
    output logic       sfx_busy
);

    localparam int PER_MAX = (TONE_LAND > TONE_CLEAR) ? TONE_LAND : TONE_CLEAR;
    localparam int PER_W   = $clog2(PER_MAX + 1);
    localparam int TICK_W  = $clog2(SFX_TICK + 1);

    localparam logic [PER_W-1:0]  PER_LAND  = PER_W'(TONE_LAND);
    localparam logic [PER_W-1:0]  PER_CLEAR = PER_W'(TONE_CLEAR);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SFX_TICK - 1);

    sfx_state_t        state_q;
    logic [PER_W-1:0]  period_q;
    logic [PER_W-1:0]  tone_cnt_q;
    logic              phase_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [3:0]        env_q;
    logic [2:0]        rep_q;

    logic              tone_wrap;
    logic              tick_wrap;
    logic [MIX_W-1:0]  music_lvl;
    logic [MIX_W-1:0]  sfx_lvl;
    logic [MIX_W:0]    mix_sum;
    logic [MIX_W-1:0]  mix_level;

    assign tone_wrap = (tone_cnt_q == period_q - 1'b1);
    assign tick_wrap = (tick_cnt_q == TICK_LAST);

    // Effect sequencer: trigger arbitration, tone/envelope timing and the blip/gap cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            period_q   <= '0;
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
            tick_cnt_q <= '0;
            env_q      <= '0;
            rep_q      <= '0;
        end else if (gameover) begin
            state_q <= IDLE;
        end else if (sfx_clear != 3'd0) begin
            state_q    <= BLIP;
            period_q   <= PER_CLEAR;
            rep_q      <= clamp_repeats(sfx_clear);
            env_q      <= ENV_CLEAR;
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sfx_land) begin
                        state_q    <= BLIP;
                        period_q   <= PER_LAND;
                        rep_q      <= 3'd1;
                        env_q      <= ENV_LAND;
                        tone_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        tick_cnt_q <= '0;
                    end
                end
                BLIP: begin
                    if (tone_wrap) begin
                        tone_cnt_q <= '0;
                        phase_q    <= ~phase_q;
                    end else begin
                        tone_cnt_q <= tone_cnt_q + 1'b1;
                    end
                    if (tick_wrap) begin
                        tick_cnt_q <= '0;
                        if (env_q == 4'd1) begin
                            env_q <= 4'd0;
                            if (rep_q > 3'd1) begin
                                state_q <= GAP;
                                rep_q   <= rep_q - 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            env_q <= env_q - 1'b1;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (tick_wrap) begin
                        state_q    <= BLIP;
                        env_q      <= ENV_CLEAR;
                        tone_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        tick_cnt_q <= '0;
                        // Each later blip is pitched up by 1/8; short periods are left alone.
                        if (int'(period_q) >= 8) begin
                            period_q <= period_q - (period_q >> 3);
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Music and effect levels, saturating sum, then mute.
    always_comb begin
        music_lvl = square_in ? MIX_W'(int'(vol) * VOL_STEP) : '0;
        sfx_lvl   = (state_q == BLIP && phase_q) ? MIX_W'(int'(env_q) * SFX_GAIN) : '0;
        mix_sum   = {1'b0, music_lvl} + {1'b0, sfx_lvl};
        mix_level = mix_sum[MIX_W] ? '1 : mix_sum[MIX_W-1:0];
        if (mute) begin
            mix_level = '0;
        end
    end

    assign sfx_busy = (state_q != IDLE);

    t01_sigma_delta u_sigma_delta (
        .clk     (clk),
        .rst     (rst),
        .level_i (mix_level),
        .pwm_o   (pwm_out)
    );

endmodule
